// File: rtl/regfile_checker.sv
// Post-run register-file checker: lets the processor run for a cycle budget (or until
// its PC stalls), then walks registers 1..NREGS-1 comparing them with expected values.
module regfile_checker #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned NREGS       = 32,
  parameter int unsigned MAX_CYCLES  = 29,
  parameter int unsigned HALT_DETECT = 1,
  parameter int unsigned HALT_STABLE = 4,
  localparam int unsigned AW         = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pc,
  input  logic             exp_we,
  input  logic [AW-1:0]    exp_addr,
  input  logic [WIDTH-1:0] exp_data,
  output logic [AW-1:0]    rd_addr,
  input  logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [AW-1:0]    fail_addr,
  output logic [WIDTH-1:0] fail_actual,
  output logic [WIDTH-1:0] fail_expected,
  output logic [15:0]      cycle_count
);

  localparam int unsigned CW = 16;
  localparam int unsigned HW = 4;
  localparam logic [AW-1:0] LAST_ADDR = AW'(NREGS - 1);
  localparam logic [CW-1:0] BUDGET    = CW'(MAX_CYCLES);
  localparam logic [HW-1:0] HALT_MAX  = HW'(HALT_STABLE - 1);

  typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] exp_mem [1:NREGS-1];
  logic [WIDTH-1:0] prev_pc;
  logic             prev_valid;
  logic [HW-1:0]    halt_cnt;

  logic [CW-1:0]    cc_next;
  logic [HW-1:0]    hc_next;
  logic             run_end;
  logic [WIDTH-1:0] exp_cur;
  logic             mem_we;

  // Expected values survive reset and may only change while no run is in flight.
  assign mem_we = exp_we && (exp_addr != '0) && (exp_addr <= LAST_ADDR) &&
                  ((state == IDLE) || (state == DONE));

  always_ff @(posedge clk) begin
    if (mem_we) exp_mem[exp_addr] <= exp_data;
  end

  // Next budget/halt counts; the first RUN cycle has no previous pc to compare against.
  always_comb begin
    cc_next = (cycle_count == '1) ? cycle_count : cycle_count + CW'(1);
    hc_next = '0;
    if (prev_valid && (pc == prev_pc)) hc_next = halt_cnt + HW'(1);
    run_end = (cc_next == BUDGET) || ((HALT_DETECT != 0) && (hc_next == HALT_MAX));
    exp_cur = exp_mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      fail          <= 1'b0;
      rd_addr       <= '0;
      cycle_count   <= '0;
      fail_addr     <= '0;
      fail_actual   <= '0;
      fail_expected <= '0;
      halt_cnt      <= '0;
      prev_pc       <= '0;
      prev_valid    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state         <= RUN;
            busy          <= 1'b1;
            done          <= 1'b0;
            pass          <= 1'b0;
            fail          <= 1'b0;
            fail_addr     <= '0;
            fail_actual   <= '0;
            fail_expected <= '0;
            cycle_count   <= '0;
            halt_cnt      <= '0;
            prev_valid    <= 1'b0;
          end
        end
        RUN: begin
          cycle_count <= cc_next;
          halt_cnt    <= hc_next;
          prev_pc     <= pc;
          prev_valid  <= 1'b1;
          if (run_end) begin
            state   <= CHECK;
            rd_addr <= AW'(1);
          end
        end
        CHECK: begin
          // Stop at the first mismatch; later registers are never examined.
          if (rd_data != exp_cur) begin
            state         <= DONE;
            busy          <= 1'b0;
            done          <= 1'b1;
            fail          <= 1'b1;
            fail_addr     <= rd_addr;
            fail_actual   <= rd_data;
            fail_expected <= exp_cur;
            rd_addr       <= '0;
          end else if (rd_addr == LAST_ADDR) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= 1'b1;
            rd_addr <= '0;
          end else begin
            rd_addr <= rd_addr + AW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_checker.sv
// Randomized bench for regfile_checker: run outcomes are predicted from pc stall windows
// and the first differing register, then checked every cycle against the DUT outputs.
module tb_regfile_checker;

  localparam int unsigned W    = 32;
  localparam int unsigned NR   = 32;
  localparam int unsigned MAXC = 29;
  localparam int unsigned HS   = 4;
  localparam int unsigned AW   = 5;

  logic          clk = 1'b0;
  logic          reset, start, exp_we;
  logic [W-1:0]  pc, exp_data, rd_data, fail_actual, fail_expected;
  logic [AW-1:0] exp_addr, rd_addr, fail_addr;
  logic          busy, done, pass, fail;
  logic [15:0]   cycle_count;

  logic [W-1:0]  regs [NR];
  logic [W-1:0]  gold [NR];
  logic [W-1:0]  pcs  [MAXC+1];

  logic          m_busy, m_done, m_pass, m_fail;
  logic [AW-1:0] m_rd, m_faddr;
  logic [W-1:0]  m_fact, m_fexp;
  logic [15:0]   m_cc;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  assign rd_data = regs[rd_addr];

  always #5 clk = ~clk;

  regfile_checker #(
    .WIDTH(W), .NREGS(NR), .MAX_CYCLES(MAXC), .HALT_DETECT(1), .HALT_STABLE(HS)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pc(pc),
    .exp_we(exp_we), .exp_addr(exp_addr), .exp_data(exp_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .pass(pass), .fail(fail),
    .fail_addr(fail_addr), .fail_actual(fail_actual), .fail_expected(fail_expected),
    .cycle_count(cycle_count)
  );

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", W'(busy), W'(m_busy));
      chk("done", W'(done), W'(m_done));
      chk("pass", W'(pass), W'(m_pass));
      chk("fail", W'(fail), W'(m_fail));
      chk("rd_addr", W'(rd_addr), W'(m_rd));
      chk("cycle_count", W'(cycle_count), W'(m_cc));
      chk("fail_addr", W'(fail_addr), W'(m_faddr));
      chk("fail_actual", fail_actual, m_fact);
      chk("fail_expected", fail_expected, m_fexp);
    end
  end

  task automatic m_zero();
    m_busy = 1'b0; m_done = 1'b0; m_pass = 1'b0; m_fail = 1'b0;
    m_rd = '0; m_faddr = '0; m_fact = '0; m_fexp = '0; m_cc = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    start = 1'b0; exp_we = 1'b0;
    for (int i = 0; i < n; i++) begin
      pc = $urandom;
      tick();
    end
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [W-1:0] d);
    start = 1'b0; exp_we = 1'b1; exp_addr = a; exp_data = d; pc = $urandom;
    tick();
    exp_we = 1'b0;
    if (a != '0) gold[a] = d;
  endtask

  // Run length: first cycle closing a window of HS identical pc samples, else the budget.
  function automatic int run_len();
    int res;
    res = MAXC;
    for (int k = MAXC; k >= HS; k--) begin
      bit same;
      same = 1'b1;
      for (int i = k - HS + 2; i <= k; i++)
        if (pcs[i] !== pcs[k-HS+1]) same = 1'b0;
      if (same) res = k;
    end
    return res;
  endfunction

  task automatic do_run(input logic [W-1:0] base, input int hold, input int stall,
                        input int rst_edge, input bit noise, input bit we3);
    int len, clen, last, idx;
    bit mis, aborted;
    for (int k = 1; k <= MAXC; k++) begin
      idx = (stall > 0 && k > stall) ? stall : k;
      pcs[k] = base + W'(4 * ((idx - 1) / hold));
    end
    len = run_len();
    clen = NR - 1;
    mis = 1'b0;
    for (int j = NR - 1; j >= 1; j--)
      if (regs[j] !== gold[j]) begin clen = j; mis = 1'b1; end
    last = len + clen;
    aborted = 1'b0;
    for (int n = 0; n <= last && !aborted; n++) begin
      start    = (n == 0) || (noise && $urandom_range(0, 4) == 0);
      pc       = (n >= 1 && n <= len) ? pcs[n] : $urandom;
      exp_we   = (n >= 1) && noise && ($urandom_range(0, 3) == 0);
      exp_addr = AW'($urandom);
      exp_data = $urandom;
      if (we3 && n == 2) begin exp_we = 1'b1; exp_addr = AW'(3); exp_data = 32'h1; end
      reset = (n != rst_edge);
      if (!reset && noise) start = 1'b1;
      tick();
      if (n == rst_edge) begin
        m_zero();
        aborted = 1'b1;
      end else if (n == 0) begin
        m_zero();
        m_busy = 1'b1;
      end else if (n <= len) begin
        m_cc = 16'(n);
        if (n == len) m_rd = AW'(1);
      end else if (n < last) begin
        m_rd = AW'(n - len + 1);
      end else begin
        m_busy = 1'b0; m_done = 1'b1; m_rd = '0;
        if (mis) begin
          m_fail = 1'b1; m_faddr = AW'(clen); m_fact = regs[clen]; m_fexp = gold[clen];
        end else begin
          m_pass = 1'b1;
        end
      end
    end
    reset = 1'b1; start = 1'b0; exp_we = 1'b0;
  endtask

  initial begin
    int nl, j;
    reset = 1'b0; start = 1'b0; exp_we = 1'b0;
    exp_addr = '0; exp_data = '0; pc = '0;
    m_zero();
    for (int i = 0; i < NR; i++) begin regs[i] = '0; gold[i] = '0; end
    tick();
    chk_en = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    idle(2);

    for (int a = 1; a < NR; a++) begin
      load(AW'(a), 32'hcafebabe);
      regs[a] = 32'hcafebabe;
    end
    load('0, 32'h12345678);

    do_run($urandom, 1, 0, -1, 1'b0, 1'b0);
    chk("lit_pass_cc", W'(cycle_count), 32'd29);
    chk("lit_pass", W'(pass), 32'd1);
    chk("lit_pass_fail", W'(fail), 32'd0);
    idle(2);

    regs[7] = 32'h0000000d;
    do_run($urandom, 1, 0, -1, 1'b1, 1'b0);
    chk("lit_fail", W'(fail), 32'd1);
    chk("lit_fail_addr", W'(fail_addr), 32'd7);
    chk("lit_fail_actual", fail_actual, 32'h0000000d);
    chk("lit_fail_expected", fail_expected, 32'hcafebabe);
    chk("lit_fail_cc", W'(cycle_count), 32'd29);
    regs[7] = 32'hcafebabe;

    do_run(32'h0, 1, 3, -1, 1'b0, 1'b0);
    chk("lit_halt_cc", W'(cycle_count), 32'd6);
    chk("lit_halt_pass", W'(pass), 32'd1);

    do_run($urandom, 1, 0, int'(MAXC) + 10, 1'b0, 1'b0);
    chk("lit_rst_done", W'(done), 32'd0);
    chk("lit_rst_busy", W'(busy), 32'd0);
    idle(1);
    do_run($urandom, 1, 0, -1, 1'b0, 1'b0);
    chk("lit_rerun_pass", W'(pass), 32'd1);

    do_run($urandom, 1, 0, -1, 1'b0, 1'b1);
    chk("lit_we_run_pass", W'(pass), 32'd1);
    idle(1);

    for (int it = 0; it < 24; it++) begin
      nl = int'($urandom_range(0, 6));
      for (int q = 0; q < nl; q++) load(AW'($urandom_range(0, NR - 1)), $urandom);
      for (int a = 1; a < NR; a++) regs[a] = gold[a];
      if ($urandom_range(0, 1) == 1) begin
        j = int'($urandom_range(1, NR - 1));
        regs[j] = gold[j] ^ (32'h1 << $urandom_range(0, 31));
      end
      do_run($urandom, int'($urandom_range(1, 5)),
             ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, MAXC)) : 0,
             ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, MAXC + NR - 1)) : -1,
             1'b1, 1'b0);
      idle(int'($urandom_range(0, 3)));
    end

    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
